// File: rtl/seq_multiplier_param.sv
// seq_multiplier_param: parametrised shift-add multiplier, signed/unsigned,
// edge-triggered start, busy flag and held product.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous reset, active-high
//   start        in   request; a 0->1 transition starts an operation
//   signed_mode  in   1 = two's-complement operands, 0 = unsigned
//   A, B         in   WIDTH-bit multiplicand / multiplier
//   busy         out  operation in progress
//   end_mul      out  produto holds the last accepted result
//   produto      out  2*WIDTH-bit product
module seq_multiplier_param #(
   parameter int WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 end_mul,
   output logic [2*WIDTH-1:0]   produto
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t               r_state;
   logic                 r_start_q;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH:0]     r_acc;
   logic [WIDTH-1:0]     r_mag_a;
   logic [WIDTH-1:0]     r_mag_b;
   logic                 r_neg;
   logic                 r_busy;
   logic                 r_end;
   logic [2*WIDTH-1:0]   r_prod;

   logic                 w_accept;
   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH:0]     w_acc_add;
   logic                 w_cnt_last;
   logic [2*WIDTH-1:0]   w_res;

   assign w_accept = start && !r_start_q &&
                     ((r_state == IDLE) || (r_state == DONE));

   // |-2^(WIDTH-1)| still fits as an unsigned WIDTH-bit magnitude
   assign w_mag_a = (signed_mode && A[WIDTH-1]) ? -A : A;
   assign w_mag_b = (signed_mode && B[WIDTH-1]) ? -B : B;

   // Upper half is WIDTH+1 bits wide so the add carry is kept
   assign w_sum = r_mag_b[0] ?
                  r_acc[2*WIDTH:WIDTH] + {1'b0, r_mag_a} :
                  r_acc[2*WIDTH:WIDTH];
   assign w_acc_add = {w_sum, r_acc[WIDTH-1:0]};

   assign w_cnt_last = (r_cnt == CW'(WIDTH - 1));

   assign w_res = r_neg ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_start_q <= 1'b0;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_mag_a   <= '0;
         r_mag_b   <= '0;
         r_neg     <= 1'b0;
         r_busy    <= 1'b0;
         r_end     <= 1'b0;
         r_prod    <= '0;
      end else begin
         r_start_q <= start;
         unique case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_mag_a <= w_mag_a;
                  r_mag_b <= w_mag_b;
                  r_neg   <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_end   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= CALC;
               end
            end
            CALC: begin
               r_acc   <= w_acc_add >> 1;
               r_mag_b <= r_mag_b >> 1;
               r_cnt   <= r_cnt + CW'(1);
               if (w_cnt_last) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               r_prod  <= w_res;
               r_end   <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= DONE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy    = r_busy;
   assign end_mul = r_end;
   assign produto = r_prod;

endmodule

// File: doc/seq_multiplier_param.md
Name: seq_multiplier_param

Overview:
Parametrised sequential shift-add multiplier. It is the successor of the fixed 32-bit start/end_mul multiplier, generalised to any operand width and adding signed/unsigned mode, edge-triggered start, and a busy flag. It sits as a multi-cycle arithmetic unit driven by a controller or FSM that issues start and waits for end_mul. The product register holds its value until the next result is written.

Parameters:
WIDTH, 32, operand width in bits (legal range 2..64); the product is 2*WIDTH bits.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous reset, active-high.
start  in  1  request; only a 0->1 transition starts an operation.
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled at acceptance.
A  in  WIDTH  multiplicand; sampled at acceptance.
B  in  WIDTH  multiplier; sampled at acceptance.
busy  out  1  high while an operation is in progress.
end_mul  out  1  high while produto holds the result of the last accepted operation.
produto  out  2*WIDTH  product.

Behaviour:
- One clock domain. Reset is synchronous and active-high: all registers update only on the rising edge of clock, and reset has priority over every other input.
- Reset values: state=IDLE, busy=0, end_mul=0, produto=0, internal start_q=0, counter=0, accumulator=0.
- start_q registers start every cycle. Acceptance condition: start=1 && start_q=0 && state is IDLE or DONE.
  - A start held high for many cycles therefore launches exactly one operation.
  - A rising start edge in CALC or FIX is ignored and is not queued.
- States:
  - IDLE: wait for acceptance.
  - CALC: WIDTH iterations.
  - FIX: apply sign and write the result.
  - DONE: result valid; acceptance of a new operation is allowed.
- Acceptance edge (edge k):
  - Latch magA=|A| and magB=|B| as WIDTH-bit unsigned values. Magnitude is taken only if signed_mode=1 and the operand MSB=1; otherwise the raw value is used.
  - Latch neg = signed_mode & (A[MSB] ^ B[MSB]).
  - Clear accumulator and counter; set end_mul=0, busy=1, state=CALC.
  - produto keeps its old value.
- Most-negative operand: |-2^(WIDTH-1)| = 2^(WIDTH-1) fits the unsigned WIDTH-bit magnitude, so no overflow is possible.
- CALC, edges k+1 .. k+WIDTH: one radix-2 step per edge.
  - If the multiplier LSB is 1, add magA into the upper half of the 2*WIDTH+1-bit accumulator.
  - Then shift the accumulator right by 1 and increment counter.
  - When counter reaches WIDTH-1 on an edge, the next state is FIX.
- FIX, edge k+WIDTH+1:
  - produto = neg ? -acc : acc (2*WIDTH bits, two's complement).
  - end_mul=1, busy=0, state=DONE.
- Latency: end_mul rises WIDTH+1 edges after the acceptance edge (33 for WIDTH=32). Back-to-back throughput is one operation per WIDTH+2 cycles minimum.
- DONE: produto and end_mul are held indefinitely. A new acceptance behaves exactly as from IDLE, including end_mul dropping on the acceptance edge.
- Changes on A, B or signed_mode after acceptance have no effect on the running operation.
- Reset mid-operation: on the next edge all outputs return to reset values and the partial result is discarded.
  - If start is still high when reset is released, start_q=0, so that level counts as a rising edge on the first cycle after reset.
- Unsigned results are exact over the full range; signed results are exact for all operand pairs.

Test Plan:
- WIDTH=32, unsigned, A=32'hFFFFFFFF, B=32'hFFFFFFFF, start held 2 cycles -> exactly one operation; busy high for 33 cycles; end_mul rises 33 edges after acceptance; produto=64'hFFFFFFFE00000001.
- Signed: A=32'hFFFFFFFF, B=32'hFFFFFFFF -> 64'h0000000000000001. A=32'h80000000, B=32'h80000000 -> 64'h4000000000000000. A=32'hFFFFFFFF, B=32'h00000002 -> 64'hFFFFFFFFFFFFFFFE.
- Unsigned A=32'h12345678, B=32'h00000010 -> 64'h0000000123456780. Then a new start edge with A=0 -> end_mul drops on the acceptance edge; the old produto is held until FIX writes 0.
- Start toggled 0->1 mid-CALC with different operands -> ignored; the original result and latency are unchanged.
- Reset asserted for 1 cycle at iteration 10 -> next edge busy=0, end_mul=0, produto=0; a fresh start then completes correctly.
- WIDTH=8 instance: signed 8'hFF*8'hFF -> 16'h0001; unsigned 8'hFF*8'hFF -> 16'hFE01; end_mul rises 9 edges after acceptance.
